spike_packet_router: RTL and testbench

SPIKE_PACKET_ROUTER -- requirements
Module: spike_packet_router

---
 rtl/snn_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 57 +++++
 rtl/spike_packet_router.sv | 64 ++++++
 tb/tb_spike_packet_router.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared packet layout, PE addresses and type codes for the spike router.
package snn_pkg;

  localparam int unsigned PKT_W = 34;

  localparam int unsigned DEST_HI    = 33;
  localparam int unsigned DEST_LO    = 30;
  localparam int unsigned SRC_HI     = 29;
  localparam int unsigned SRC_LO     = 26;
  localparam int unsigned TYPE_HI    = 25;
  localparam int unsigned TYPE_LO    = 24;
  localparam int unsigned PAYLOAD_HI = 7;
  localparam int unsigned PAYLOAD_LO = 0;

  localparam logic [3:0] PE1_ADDR = 4'b1000;
  localparam logic [3:0] PE2_ADDR = 4'b1001;
  localparam logic [3:0] PE3_ADDR = 4'b1010;

  typedef enum logic [1:0] {
    PktSpike = 2'b10,
    PktRsvd  = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    pkt_type_e   ptype;
    logic [15:0] rsvd;
    logic [7:0]  payload;
  } pkt_t;

  // One-hot port select: base, base+1, base+2 map to PE ports; anything else to error port.
  function automatic logic [3:0] port_onehot(logic [3:0] dest, logic [3:0] base);
    logic [3:0] sel;
    sel = 4'b1000;
    if (dest == base) begin
      sel = 4'b0001;
    end else if (dest == 4'(base + 4'd1)) begin
      sel = 4'b0010;
    end else if (dest == 4'(base + 4'd2)) begin
      sel = 4'b0100;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy counter separates full from empty, head reads 0 when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; the empty gate below keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr_q];

endmodule

// File: rtl/spike_packet_router.sv
// Spike packet router: filters reserved-type packets, queues the rest, steers head to one port.
module spike_packet_router
  import snn_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  PE_BASE = PE1_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic [7:0]       drop_cnt
);

  logic             ready_q;
  logic [7:0]       drop_cnt_q;
  logic             full, empty;
  logic             accept, is_rsvd, push, pop;
  logic [PKT_W-1:0] head;

  // Held low through reset and released by the first clock edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign in_ready = ready_q & ~full;
  assign accept   = in_valid & in_ready;
  assign is_rsvd  = (in_data[TYPE_HI:TYPE_LO] == PktRsvd);
  assign push     = accept & ~is_rsvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && is_rsvd && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;

  sync_fifo #(
    .WIDTH(PKT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(in_data),
    .pop  (pop),
    .rdata(head),
    .empty(empty),
    .full (full)
  );

  assign out_valid = empty ? 4'b0000 : port_onehot(head[DEST_HI:DEST_LO], PE_BASE);
  assign out_data  = head;
  assign pop       = |(out_valid & out_ready);

endmodule

// File: tb/tb_spike_packet_router.sv
// Directed bench for spike_packet_router with a queue-based reference model.
module tb_spike_packet_router;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [33:0] in_data = '0;
  logic [3:0]  out_ready = '0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [33:0] out_data;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [33:0] mq[$];
  int          mdrop = 0;
  bit          mrdy = 1'b0;

  always #5 clk = ~clk;

  spike_packet_router #(
    .DEPTH  (DEPTH),
    .PE_BASE(4'b1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] pkt(logic [3:0] d, logic [3:0] s, logic [1:0] t,
                                      logic [7:0] p);
    return {d, s, t, 16'h0000, p};
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [33:0] h;
    if (mq.size() == 0) return 4'b0000;
    h = mq[0];
    case (h[33:30])
      4'd8:    return 4'b0001;
      4'd9:    return 4'b0010;
      4'd10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Compare DUT against the model, then advance both across one rising edge.
  task automatic step();
    logic [3:0]  ev;
    logic [33:0] ed;
    bit          erdy, acc, pop;
    #2;
    ev   = exp_valid();
    ed   = '0;
    if (mq.size() != 0) ed = mq[0];
    erdy = mrdy && (mq.size() < DEPTH);
    acc  = in_valid && erdy;
    pop  = |(ev & out_ready);
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (in_data[25:24] == 2'b11) begin
        if (mdrop < 255) mdrop++;
      end else begin
        mq.push_back(in_data);
      end
    end
    mrdy = 1'b1;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    mq.delete();
    mdrop = 0;
    mrdy  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("init_out_valid", 64'(out_valid), 64'h0);
    chk("init_in_ready", 64'(in_ready), 64'h0);
    chk("init_out_data", 64'(out_data), 64'h0);
    chk("init_drop_cnt", 64'(drop_cnt), 64'h0);
    #10;
    rst_n = 1'b1;
    step();

    // Basic routing: one packet to each PE, visible the cycle after acceptance.
    out_ready = 4'hF;
    in_valid  = 1'b1; in_data = pkt(4'd8, 4'd4, 2'b10, 8'd19); step();
    in_valid  = 1'b0; #1;
    chk("s1_port0_valid", 64'(out_valid), 64'h1);
    chk("s1_port0_payload", 64'(out_data[7:0]), 64'd19);
    step();
    in_valid  = 1'b1; in_data = pkt(4'd9, 4'd4, 2'b10, 8'd12); step();
    in_valid  = 1'b0; #1;
    chk("s1_port1_valid", 64'(out_valid), 64'h2);
    chk("s1_port1_payload", 64'(out_data[7:0]), 64'd12);
    step();
    in_valid  = 1'b1; in_data = pkt(4'd10, 4'd4, 2'b10, 8'd39); step();
    in_valid  = 1'b0; #1;
    chk("s1_port2_valid", 64'(out_valid), 64'h4);
    chk("s1_port2_payload", 64'(out_data[7:0]), 64'd39);
    step();
    step();

    // Backpressure: fill, stall the fifth, then drain through port 0.
    out_ready = 4'h0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = pkt(4'd8, 4'd1, 2'b10, 8'(60 + i));
      step();
    end
    in_data = pkt(4'd8, 4'd1, 2'b10, 8'd64);
    #1;
    chk("s2_full_in_ready", 64'(in_ready), 64'h0);
    step();
    out_ready = 4'b0001;
    step();
    #1;
    chk("s2_ready_after_pop", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Head-of-line blocking: PE2 head stalls the PE1 packet behind it.
    out_ready = 4'h0;
    in_valid  = 1'b1;
    in_data   = pkt(4'd9, 4'd2, 2'b10, 8'd70); step();
    in_data   = pkt(4'd8, 4'd2, 2'b10, 8'd71); step();
    in_valid  = 1'b0;
    out_ready = 4'b0001;
    repeat (3) step();
    #1;
    chk("s3_blocked_valid", 64'(out_valid), 64'h2);
    chk("s3_blocked_payload", 64'(out_data[7:0]), 64'd70);
    out_ready = 4'b0011;
    repeat (3) step();

    // Drop and unmapped, then saturation of the drop counter.
    out_ready = 4'h0;
    in_valid  = 1'b1;
    in_data   = pkt(4'd8, 4'd3, 2'b11, 8'd80); step();
    in_data   = pkt(4'd15, 4'd3, 2'b10, 8'd81); step();
    in_valid  = 1'b0;
    #1;
    chk("s4_drop_one", 64'(drop_cnt), 64'd1);
    chk("s4_unmapped_valid", 64'(out_valid), 64'h8);
    chk("s4_unmapped_payload", 64'(out_data[7:0]), 64'd81);
    out_ready = 4'hF;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = pkt(4'd8, 4'd3, 2'b11, 8'(i));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("s4_drop_sat", 64'(drop_cnt), 64'd255);
    chk("s4_nothing_queued", 64'(out_valid), 64'h0);
    step();

    // Reset with packets queued.
    out_ready = 4'h0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = pkt(4'd9, 4'd5, 2'b10, 8'(90 + i));
      step();
    end
    in_valid = 1'b0;
    do_reset();
    step();
    #1;
    chk("s5_ready_after_edge", 64'(in_ready), 64'h1);
    chk("s5_empty_after_rst", 64'(out_valid), 64'h0);
    step();

    // Simultaneous push/pop at occupancy 2.
    out_ready = 4'h0;
    in_valid  = 1'b1;
    in_data   = pkt(4'd10, 4'd6, 2'b10, 8'd50); step();
    in_data   = pkt(4'd10, 4'd6, 2'b10, 8'd51); step();
    out_ready = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      in_data = pkt(4'd10, 4'd6, 2'b10, 8'(100 + i));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("s6_head_payload", 64'(out_data[7:0]), 64'd108);
    chk("s6_head_valid", 64'(out_valid), 64'h4);
    out_ready = 4'hF;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
